// File: rtl/matrix_mac_if.sv
// Operand/result bus of matrix_mac_engine: flattened row-major matrices with stb/ack handshakes.
// master = operand loader and result sink side, slave = engine side.
interface matrix_mac_if #(
  parameter int M          = 4,
  parameter int P          = 4,
  parameter int N          = 4,
  parameter int word_width = 16
);
  logic [M*P*word_width-1:0] matrix_A;
  logic [P*N*word_width-1:0] matrix_B;
  logic                      a_stb;
  logic                      b_stb;
  logic                      signed_mode;
  logic                      c_ack;
  logic                      a_ack;
  logic                      b_ack;
  logic [M*N*word_width-1:0] matrix_C;
  logic                      c_stb;
  logic                      busy;

  modport master (
    output matrix_A, matrix_B, a_stb, b_stb, signed_mode, c_ack,
    input  a_ack, b_ack, matrix_C, c_stb, busy
  );

  modport slave (
    input  matrix_A, matrix_B, a_stb, b_stb, signed_mode, c_ack,
    output a_ack, b_ack, matrix_C, c_stb, busy
  );
endinterface

// File: rtl/matrix_mac_engine.sv
// Sequential C(MxN) = A(MxP) * B(PxN): M MAC lanes, one C column every P cycles.
// Optional define MME_SAT_EN: clamp each written C element to the output range instead of wrapping.
module matrix_mac_engine #(
  parameter int M          = 4,
  parameter int P          = 4,
  parameter int N          = 4,
  parameter int word_width = 16
) (
  input  logic        clk,
  input  logic        rst,
  matrix_mac_if.slave bus
);
  localparam int ACC_W  = 2*word_width + $clog2(P);
  localparam int PROD_W = 2*word_width + 2;
  localparam int KW     = (P > 1) ? $clog2(P) : 1;
  localparam int JW     = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state, state_nxt;
  logic                      accept;
  logic                      last_k, last_j;

  logic [M*P*word_width-1:0] a_lat;
  logic [P*N*word_width-1:0] b_lat;
  logic                      mode_lat;

  logic signed [ACC_W-1:0]   sum_p0 [M];
  logic signed [ACC_W-1:0]   acc_p1 [M];
  logic [KW-1:0]             k_p1;
  logic [JW-1:0]             j_p1;
  logic [M*N*word_width-1:0] c_p1;
  logic                      ack_p1;

  // Operands get one extra bit so a single signed multiplier serves both modes.
  function automatic logic signed [ACC_W-1:0] mac_prod(
    input logic [word_width-1:0] a,
    input logic [word_width-1:0] b,
    input logic                  sgn
  );
    logic signed [word_width:0] ae, be;
    logic signed [PROD_W-1:0]   pr;
    ae = sgn ? {a[word_width-1], a} : {1'b0, a};
    be = sgn ? {b[word_width-1], b} : {1'b0, b};
    pr = ae * be;
    return ACC_W'(pr);
  endfunction

`ifdef MME_SAT_EN
  localparam logic signed [ACC_W:0] S_MAX = {{(ACC_W-word_width+2){1'b0}}, {(word_width-1){1'b1}}};
  localparam logic signed [ACC_W:0] S_MIN = {{(ACC_W-word_width+2){1'b1}}, {(word_width-1){1'b0}}};
  localparam logic signed [ACC_W:0] U_MAX = {{(ACC_W-word_width+1){1'b0}}, {word_width{1'b1}}};

  // Unsigned sums are never negative, so only the upper bound applies there.
  function automatic logic [word_width-1:0] sat_word(
    input logic signed [ACC_W-1:0] v,
    input logic                    sgn
  );
    logic signed [ACC_W:0] sv;
    sv = sgn ? {v[ACC_W-1], v} : {1'b0, v};
    if (sgn) begin
      if (sv > S_MAX)      return S_MAX[word_width-1:0];
      else if (sv < S_MIN) return S_MIN[word_width-1:0];
      else                 return v[word_width-1:0];
    end else begin
      if (sv > U_MAX)      return U_MAX[word_width-1:0];
      else                 return v[word_width-1:0];
    end
  endfunction
`endif

  assign last_k = (k_p1 == KW'(P-1));
  assign last_j = (j_p1 == JW'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.a_stb && bus.b_stb) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: if (last_k && last_j) state_nxt = DONE;
      DONE: if (bus.c_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch: captured only on accept, so later input changes cannot disturb a run.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lat    <= bus.matrix_A;
      b_lat    <= bus.matrix_B;
      mode_lat <= bus.signed_mode;
    end
  end

  // Stage p0: every lane adds A[i][k]*B[k][j] to its running sum.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      sum_p0[i] = acc_p1[i] + mac_prod(
        a_lat[(i*P + int'(k_p1))*word_width +: word_width],
        b_lat[(int'(k_p1)*N + int'(j_p1))*word_width +: word_width],
        mode_lat);
    end
  end

  // Stage p1: accumulate, or write the finished column and restart the sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_p1   <= '0;
      j_p1   <= '0;
      c_p1   <= '0;
      ack_p1 <= 1'b0;
      for (int i = 0; i < M; i++) acc_p1[i] <= '0;
    end else begin
      ack_p1 <= accept;
      if (accept) begin
        k_p1 <= '0;
        j_p1 <= '0;
        for (int i = 0; i < M; i++) acc_p1[i] <= '0;
      end else if (state == CALC) begin
        if (last_k) begin
          k_p1 <= '0;
          j_p1 <= last_j ? '0 : j_p1 + 1'b1;
          for (int i = 0; i < M; i++) begin
            acc_p1[i] <= '0;
`ifdef MME_SAT_EN
            c_p1[(i*N + int'(j_p1))*word_width +: word_width] <= sat_word(sum_p0[i], mode_lat);
`else
            c_p1[(i*N + int'(j_p1))*word_width +: word_width] <= sum_p0[i][word_width-1:0];
`endif
          end
        end else begin
          k_p1 <= k_p1 + 1'b1;
          for (int i = 0; i < M; i++) acc_p1[i] <= sum_p0[i];
        end
      end
    end
  end

  assign bus.a_ack    = ack_p1;
  assign bus.b_ack    = ack_p1;
  assign bus.matrix_C = c_p1;
  assign bus.c_stb    = (state == DONE);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine (4x4x4, 16-bit); expected results go to a queue
// that a negedge monitor pops whenever c_stb rises.
module tb_matrix_mac_engine;
  logic clk = 1'b0;
  logic rst;

  matrix_mac_if #(.M(4), .P(4), .N(4), .word_width(16)) bus ();

  matrix_mac_engine #(.M(4), .P(4), .N(4), .word_width(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [255:0] exp_q[$];
  logic         in_done = 1'b0;
  logic [255:0] held_c;

  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [255:0] pack(input int v[16]);
    logic [255:0] r;
    r = '0;
    for (int e = 0; e < 16; e++) r[e*16 +: 16] = 16'(v[e]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.c_stb) begin
      if (!in_done) begin
        in_done = 1'b1;
        held_c  = bus.matrix_C;
        if (exp_q.size() == 0) chk_int("unexpected_result", 1, 0);
        else chk_vec("result", bus.matrix_C, exp_q.pop_front());
      end else begin
        chk_vec("c_stable", bus.matrix_C, held_c);
      end
    end else begin
      in_done = 1'b0;
    end
  end

  // Waits for c_stb after an accept edge; expects it exactly N*P = 16 edges later.
  task automatic wait_result();
    int cyc;
    cyc = 0;
    while (!bus.c_stb && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk_bit("ack_pulse_end", bus.a_ack, 1'b0);
    end
    chk_int("latency", cyc, 16);
  endtask

  task automatic start_op(input logic [255:0] a, input logic [255:0] b, input logic mode,
                          input logic [255:0] exp_c);
    bus.matrix_A    = a;
    bus.matrix_B    = b;
    bus.signed_mode = mode;
    bus.a_stb       = 1'b1;
    bus.b_stb       = 1'b1;
    exp_q.push_back(exp_c);
    @(posedge clk); #1;
    chk_bit("a_ack", bus.a_ack, 1'b1);
    chk_bit("b_ack", bus.b_ack, 1'b1);
    chk_bit("busy_calc", bus.busy, 1'b1);
    bus.a_stb = 1'b0;
    bus.b_stb = 1'b0;
    wait_result();
  endtask

  task automatic ack_done(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk_bit("c_stb_hold", bus.c_stb, 1'b1);
    end
    bus.c_ack = 1'b1;
    @(posedge clk); #1;
    bus.c_ack = 1'b0;
    chk_bit("c_stb_after_ack", bus.c_stb, 1'b0);
    chk_bit("busy_after_ack", bus.busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ida[16], bseq[16], a2i[16], b2x[16], as[16], bs[16], cs[16];
    int ab2[16], bb2[16], cb2[16], c2b[16], cmb[16], fill_a[16], fill_b[16], fill_c[16];

    rst             = 1'b1;
    bus.matrix_A    = '0;
    bus.matrix_B    = '0;
    bus.a_stb       = 1'b0;
    bus.b_stb       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.c_ack       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_a_ack", bus.a_ack, 1'b0);
    chk_bit("rst_b_ack", bus.b_ack, 1'b0);
    chk_bit("rst_c_stb", bus.c_stb, 1'b0);
    chk_bit("rst_busy", bus.busy, 1'b0);
    chk_vec("rst_matrix_C", bus.matrix_C, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity: C equals B
    ida = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    for (int e = 0; e < 16; e++) bseq[e] = e;
    start_op(pack(ida), pack(bseq), 1'b0, pack(bseq));
    ack_done(0);

    // Signed 2x2 embedded in the top-left corner
    as = '{-1,2,0,0, 3,-4,0,0, 0,0,0,0, 0,0,0,0};
    bs = '{5,6,0,0, 7,8,0,0, 0,0,0,0, 0,0,0,0};
    cs = '{9,10,0,0, -13,-14,0,0, 0,0,0,0, 0,0,0,0};
    start_op(pack(as), pack(bs), 1'b1, pack(cs));
    ack_done(0);

    // Lone a_stb: nothing happens
    bus.a_stb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk_bit("lone_stb_a_ack", bus.a_ack, 1'b0);
      chk_bit("lone_stb_b_ack", bus.b_ack, 1'b0);
      chk_bit("lone_stb_busy", bus.busy, 1'b0);
    end
    bus.a_stb = 1'b0;
    @(posedge clk); #1;

    // Result held for 10 cycles without c_ack
    start_op(pack(ida), pack(bseq), 1'b0, pack(bseq));
    ack_done(10);

    // Unsigned overflow: 4 * 0xFFFF^2
    for (int e = 0; e < 16; e++) begin
      fill_a[e] = 65535;
`ifdef MME_SAT_EN
      fill_c[e] = 65535;
`else
      fill_c[e] = 4;
`endif
    end
    start_op(pack(fill_a), pack(fill_a), 1'b0, pack(fill_c));
    ack_done(0);

    // Signed positive overflow: 4 * (-32768)^2 = 2^32
    for (int e = 0; e < 16; e++) begin
      fill_a[e] = -32768;
`ifdef MME_SAT_EN
      fill_c[e] = 32767;
`else
      fill_c[e] = 0;
`endif
    end
    start_op(pack(fill_a), pack(fill_a), 1'b1, pack(fill_c));
    ack_done(0);

    // Signed negative overflow: 4 * (-32768 * 32767) = -(2^32 - 2^17)
    for (int e = 0; e < 16; e++) begin
      fill_b[e] = 32767;
`ifdef MME_SAT_EN
      fill_c[e] = -32768;
`else
      fill_c[e] = 0;
`endif
    end
    start_op(pack(fill_a), pack(fill_b), 1'b1, pack(fill_c));
    ack_done(0);

    // Nonzero result in place before the aborted run
    start_op(pack(ida), pack(bseq), 1'b0, pack(bseq));
    ack_done(0);

    // Reset during CALC cycle 7
    bus.matrix_A = pack(ida);
    bus.matrix_B = pack(bseq);
    bus.a_stb    = 1'b1;
    bus.b_stb    = 1'b1;
    @(posedge clk); #1;
    bus.a_stb = 1'b0;
    bus.b_stb = 1'b0;
    chk_bit("abort_busy_before", bus.busy, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_bit("abort_busy", bus.busy, 1'b0);
    chk_bit("abort_c_stb", bus.c_stb, 1'b0);
    chk_bit("abort_a_ack", bus.a_ack, 1'b0);
    chk_vec("abort_matrix_C", bus.matrix_C, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ab2 = '{1,2,0,0, 3,4,0,0, 0,0,0,0, 0,0,0,0};
    bb2 = '{5,6,0,0, 7,8,0,0, 0,0,0,0, 0,0,0,0};
    cb2 = '{19,22,0,0, 43,50,0,0, 0,0,0,0, 0,0,0,0};
    start_op(pack(ab2), pack(bb2), 1'b0, pack(cb2));
    ack_done(0);

    // Back-to-back: second pair waiting when c_ack arrives
    for (int e = 0; e < 16; e++) c2b[e] = 2*e;
    a2i = '{2,0,0,0, 0,2,0,0, 0,0,2,0, 0,0,0,2};
    start_op(pack(a2i), pack(bseq), 1'b0, pack(c2b));
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        fill_a[i*4+k] = i + 1;
        b2x[k*4+i]    = i + 1;
      end
    cmb = '{4,8,12,16, 8,16,24,32, 12,24,36,48, 16,32,48,64};
    bus.matrix_A = pack(fill_a);
    bus.matrix_B = pack(b2x);
    bus.a_stb    = 1'b1;
    bus.b_stb    = 1'b1;
    bus.c_ack    = 1'b1;
    exp_q.push_back(pack(cmb));
    @(posedge clk); #1;
    bus.c_ack = 1'b0;
    chk_bit("b2b_c_stb_low", bus.c_stb, 1'b0);
    chk_bit("b2b_no_ack_in_done", bus.a_ack, 1'b0);
    chk_bit("b2b_idle", bus.busy, 1'b0);
    @(posedge clk); #1;
    chk_bit("b2b_a_ack", bus.a_ack, 1'b1);
    chk_bit("b2b_busy", bus.busy, 1'b1);
    bus.a_stb = 1'b0;
    bus.b_stb = 1'b0;
    for (int e = 0; e < 16; e++) begin
      fill_a[e] = 16'h1234;
      fill_b[e] = 16'h0777;
    end
    bus.matrix_A = pack(fill_a);
    bus.matrix_B = pack(fill_b);
    wait_result();
    ack_done(2);

    @(posedge clk); #1;
    chk_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
